// File: rtl/serial_resp_framer.sv
// Packs one addr/data response into a 7-byte frame (sync, addr, data LSB first, checksum)
// and paces the bytes into serialtx with a fixed clock gap between strobes.
module serial_resp_framer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned BYTE_GAP  = 168,
    parameter int unsigned GAP_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_data,
    output logic        xmit,
    output logic [7:0]  txchar,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    // The SEND cycle is the first clock of each byte slot, so GAP covers the other G-1 clocks.
    localparam logic [GAP_W-1:0] GapLoad = GAP_W'(BYTE_GAP - 2);

    logic [1:0]       state_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_next;
    logic [GAP_W-1:0] gap_q;
    logic [7:0]       addr_q;
    logic [31:0]      data_q;
    logic [7:0]       txchar_q;
    logic             frame_done_q;
    logic [7:0]       cksum;
    logic [7:0]       next_byte;

    assign req_ready  = (state_q == StIdle) && !rst;
    assign xmit       = (state_q == StSend);
    assign txchar     = txchar_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

    assign idx_next = idx_q + 3'd1;
    assign cksum    = 8'd0 - (addr_q + data_q[7:0] + data_q[15:8] + data_q[23:16]
                              + data_q[31:24]);

    always_comb begin
        next_byte = 8'h00;
        unique case (idx_next)
            3'd1:    next_byte = addr_q;
            3'd2:    next_byte = data_q[7:0];
            3'd3:    next_byte = data_q[15:8];
            3'd4:    next_byte = data_q[23:16];
            3'd5:    next_byte = data_q[31:24];
            3'd6:    next_byte = cksum;
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= 3'd0;
            gap_q        <= '0;
            addr_q       <= 8'h00;
            data_q       <= 32'h0;
            txchar_q     <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        data_q   <= req_data;
                        txchar_q <= SYNC_BYTE;
                        idx_q    <= 3'd0;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    gap_q   <= GapLoad;
                    state_q <= StGap;
                end
                StGap: begin
                    if (gap_q == '0) begin
                        if (idx_q < 3'd6) begin
                            idx_q    <= idx_next;
                            txchar_q <= next_byte;
                            state_q  <= StSend;
                        end else begin
                            idx_q        <= 3'd0;
                            frame_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_resp_framer.sv
// Scoreboard bench for serial_resp_framer: stimulus pushes expected bytes/cycles,
// a negedge monitor pops and compares whenever xmit or frame_done is seen.
module tb_serial_resp_framer;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_data = 32'h0;
    logic        xmit;
    logic [7:0]  txchar;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   fd_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_xmit = 1'b0;
    logic [7:0] frame_sum = 8'h00;
    int   byte_pos = 0;

    serial_resp_framer #(
        .SYNC_BYTE (8'hA5),
        .BYTE_GAP  (G),
        .GAP_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .xmit       (xmit),
        .txchar     (txchar),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe and frame_done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst && xmit) begin
            chk("xmit_back_to_back", {31'b0, prev_xmit}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_xmit", {31'b0, xmit}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("txchar", {24'b0, txchar}, {24'b0, e.b});
                chk("xmit_cycle", cyc, e.cyc);
                if (byte_pos == 0) frame_sum = 8'h00;
                else frame_sum = frame_sum + txchar;
                if (byte_pos == 6) chk("frame_sum", {24'b0, frame_sum}, 32'd0);
                byte_pos = (byte_pos == 6) ? 0 : byte_pos + 1;
            end
        end
        if (!rst && frame_done) begin
            if (fd_q.size() == 0) chk("unexpected_frame_done", {31'b0, frame_done}, 32'd0);
            else chk("frame_done_cycle", cyc, fd_q.pop_front());
        end
        prev_xmit = xmit;
    end

    // Presents a request, waits for acceptance, and pushes the hand-computed frame.
    task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [7:0] ck,
                         input bit hold, output int t);
        logic [7:0] fb[7];
        int n;
        fb[0] = 8'hA5; fb[1] = a; fb[2] = d[7:0]; fb[3] = d[15:8];
        fb[4] = d[23:16]; fb[5] = d[31:24]; fb[6] = ck;
        req_addr  = a;
        req_data  = d;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
        t = cyc;
        for (int k = 0; k < 7; k++) exp_q.push_back('{b: fb[k], cyc: t + 1 + k * G});
        fd_q.push_back(t + 1 + 7 * G);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fd_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain", exp_q.size() + fd_q.size(), 32'd0);
    endtask

    initial begin
        int t1, t2, n;

        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_xmit", {31'b0, xmit}, 32'd0);
        chk("rst_txchar", {24'b0, txchar}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_no_busy", {31'b0, busy}, 32'd0);

        // Single frame, then a back-to-back second word with req_valid held high.
        @(posedge clk);
        #1;
        issue(8'h12, 32'hDEADBEEF, 8'hB6, 1'b1, t1);
        @(negedge clk);
        chk("busy_in_frame", {31'b0, busy}, 32'd1);
        chk("ready_in_frame", {31'b0, req_ready}, 32'd0);
        issue(8'h34, 32'h00000001, 8'hCB, 1'b0, t2);
        chk("b2b_accept_cycle", t2, t1 + 1 + 7 * G);
        drain();

        // All-zero payload.
        @(posedge clk);
        #1;
        issue(8'h00, 32'h00000000, 8'h00, 1'b0, t1);
        drain();

        // Reset one clock right after the third strobe.
        @(posedge clk);
        #1;
        issue(8'h7F, 32'h11223344, 8'hD7, 1'b0, t1);
        n = 0;
        while (exp_q.size() != 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("third_xmit_seen", exp_q.size(), 32'd4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        fd_q.delete();
        byte_pos = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_txchar", {24'b0, txchar}, 32'd0);
        repeat (8 * G) @(negedge clk);
        @(posedge clk);
        #1;
        issue(8'h01, 32'h00000000, 8'hFF, 1'b0, t1);
        drain();

        // Input data changes after acceptance must not reach the frame.
        @(posedge clk);
        #1;
        issue(8'h56, 32'h01020304, 8'hA0, 1'b0, t1);
        req_data = 32'hFFFFFFFF;
        req_addr = 8'hFF;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
